// File: rtl/timer_array.sv
// Bank of memory-mapped timer channels sharing one prescaler; each channel counts
// prescaled ticks up to LIMIT and raises READY (and OVR on a missed READY) on expiry.
module timer_array #(
    parameter int          BITS      = 32,
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] BASE      = 32'hF0000200,
    parameter logic [31:0] STAT_BASE = 32'hF0000300,
    parameter int          TICK_DIV  = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [BITS-1:0]   memAddr,
    input  logic [BITS-1:0]   dataBusIn,
    output logic [BITS-1:0]   dataBusOut,
    output logic [NUM_CH-1:0] ready
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick;
    logic [BITS-1:0]   count_q [NUM_CH];
    logic [BITS-1:0]   count_d [NUM_CH];
    logic [BITS-1:0]   limit_q [NUM_CH];
    logic [BITS-1:0]   limit_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d, oneshot_q, oneshot_d;
    logic [NUM_CH-1:0] ready_q, ready_d, ovr_q, ovr_d;
    logic [NUM_CH-1:0] countWr, limitWr, ctrlWr, expire;

    function automatic logic [BITS-1:0] regAddr(input int ch, input int off);
        return BITS'(BASE) + BITS'(16 * ch + off);
    endfunction

    assign tick  = (presc_q == PRESC_LAST);
    assign ready = ready_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            countWr[i] = we && (memAddr == regAddr(i, 0));
            limitWr[i] = we && (memAddr == regAddr(i, 4));
            ctrlWr[i]  = we && (memAddr == regAddr(i, 8));
        end
    end

    // A bus write to COUNT suppresses that cycle's tick; expiry is applied after
    // the CTRL write so it wins over a simultaneous clear of READY or set of EN.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i]   = count_q[i];
            limit_d[i]   = limit_q[i];
            en_d[i]      = en_q[i];
            oneshot_d[i] = oneshot_q[i];
            ready_d[i]   = ready_q[i];
            ovr_d[i]     = ovr_q[i];
            expire[i]    = 1'b0;
            if (tick && en_q[i] && !countWr[i]) begin
                if (limit_q[i] == '0) begin
                    count_d[i] = count_q[i] + 1'b1;
                end else if (count_q[i] >= limit_q[i] - 1'b1) begin
                    count_d[i] = '0;
                    expire[i]  = 1'b1;
                end else begin
                    count_d[i] = count_q[i] + 1'b1;
                end
            end
            if (countWr[i]) count_d[i] = dataBusIn;
            if (limitWr[i]) limit_d[i] = dataBusIn;
            if (ctrlWr[i]) begin
                en_d[i]      = dataBusIn[0];
                oneshot_d[i] = dataBusIn[1];
                if (!dataBusIn[2]) ready_d[i] = 1'b0;
                if (!dataBusIn[3]) ovr_d[i] = 1'b0;
            end
            if (expire[i]) begin
                ready_d[i] = 1'b1;
                if (ready_q[i]) ovr_d[i] = 1'b1;
                if (oneshot_q[i]) en_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            en_q      <= '0;
            oneshot_q <= '0;
            ready_q   <= '0;
            ovr_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
                limit_q[i] <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= count_d[i];
                limit_q[i] <= limit_d[i];
            end
        end
    end

    // Output is forced to zero when not selected so several blocks can be OR-ed.
    always_comb begin
        dataBusOut = '0;
        if (re) begin
            if (memAddr == BITS'(STAT_BASE)) dataBusOut = BITS'(ready_q);
            for (int i = 0; i < NUM_CH; i++) begin
                if (memAddr == regAddr(i, 0)) dataBusOut = count_q[i];
                if (memAddr == regAddr(i, 4)) dataBusOut = limit_q[i];
                if (memAddr == regAddr(i, 8))
                    dataBusOut = BITS'({ovr_q[i], ready_q[i], oneshot_q[i], en_q[i]});
            end
        end
    end

endmodule

// File: tb/tb_timer_array.sv
// Self-checking bench for timer_array: directed scenarios plus randomized bus traffic
// compared against a behavioural model of the register map and tick rules.
module tb_timer_array;

    localparam int          BITS   = 32;
    localparam int          NUM_CH = 4;
    localparam int          TD     = 4;
    localparam logic [31:0] BASE   = 32'hF0000200;
    localparam logic [31:0] STAT   = 32'hF0000300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] dataBusIn = '0;
    logic [31:0] dataBusOut;
    logic [3:0]  ready;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mCount [NUM_CH];
    logic [31:0] mLimit [NUM_CH];
    logic        mEn  [NUM_CH];
    logic        mOs  [NUM_CH];
    logic        mRdy [NUM_CH];
    logic        mOvr [NUM_CH];
    int          mPresc = 0;
    int          mTicks = 0;

    timer_array #(
        .BITS(BITS), .NUM_CH(NUM_CH), .BASE(BASE), .STAT_BASE(STAT), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
        .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .ready(ready)
    );

    always #50 clk = ~clk;

    function automatic logic [31:0] chAddr(input int ch, input int off);
        return BASE + 32'(16 * ch + off);
    endfunction

    function automatic logic [3:0] modelReady();
        logic [3:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = mRdy[i];
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (a == STAT) v = {28'd0, modelReady()};
        for (int i = 0; i < NUM_CH; i++) begin
            if (a == chAddr(i, 0)) v = mCount[i];
            if (a == chAddr(i, 4)) v = mLimit[i];
            if (a == chAddr(i, 8)) v = {28'd0, mOvr[i], mRdy[i], mOs[i], mEn[i]};
        end
        return v;
    endfunction

    task automatic modelReset();
        mPresc = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            mCount[i] = '0; mLimit[i] = '0;
            mEn[i] = 1'b0; mOs[i] = 1'b0; mRdy[i] = 1'b0; mOvr[i] = 1'b0;
        end
    endtask

    // One clock of the timer as described by its rules, using pre-edge state.
    task automatic modelStep(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic isTick, expired, oldEn, oldOs, oldRdy;
        isTick = (mPresc == TD - 1);
        mPresc = (mPresc + 1) % TD;
        if (isTick) mTicks++;
        for (int i = 0; i < NUM_CH; i++) begin
            oldEn = mEn[i]; oldOs = mOs[i]; oldRdy = mRdy[i];
            expired = 1'b0;
            if (isTick && oldEn && !(w && a == chAddr(i, 0))) begin
                if (mLimit[i] == 0) mCount[i] = mCount[i] + 32'd1;
                else if (mCount[i] >= mLimit[i] - 32'd1) begin
                    mCount[i] = '0;
                    expired = 1'b1;
                end else mCount[i] = mCount[i] + 32'd1;
            end
            if (w && a == chAddr(i, 0)) mCount[i] = d;
            if (w && a == chAddr(i, 4)) mLimit[i] = d;
            if (w && a == chAddr(i, 8)) begin
                mEn[i] = d[0]; mOs[i] = d[1];
                if (!d[2]) mRdy[i] = 1'b0;
                if (!d[3]) mOvr[i] = 1'b0;
            end
            if (expired) begin
                mRdy[i] = 1'b1;
                if (oldRdy) mOvr[i] = 1'b1;
                if (oldOs) mEn[i] = 1'b0;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) modelReset();
        else modelStep(we, memAddr, dataBusIn);
    end

    task automatic busCycle(input logic w, input logic [31:0] a, input logic [31:0] d);
        we = w; memAddr = a; dataBusIn = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        vectors++;
        if (ready !== modelReady()) begin
            miscompares++;
            $display("[TB] FAIL ready_out got %h expected %h", ready, modelReady());
        end
    endtask

    task automatic readCheck(input logic [31:0] a, input logic [31:0] exp, input string name);
        re = 1'b1; memAddr = a;
        #1;
        vectors++;
        if (dataBusOut !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s addr %h got %h expected %h", name, a, dataBusOut, exp);
        end
        re = 1'b0;
    endtask

    task automatic checkReady(input logic [3:0] exp, input string name);
        vectors++;
        if (ready !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got %h expected %h", name, ready, exp);
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < NUM_CH; i++)
            for (int off = 0; off <= 12; off += 4)
                readCheck(chAddr(i, off), modelRead(chAddr(i, off)), "model_reg");
        readCheck(STAT, modelRead(STAT), "model_status");
    endtask

    task automatic waitTicks(input int n);
        int target;
        target = mTicks + n;
        for (int k = 0; k < n * TD + TD && mTicks < target; k++) busCycle(1'b0, '0, '0);
        if (mTicks < target) begin
            miscompares++;
            $display("[TB] FAIL tick_wait got %0d expected %0d", mTicks, target);
        end
    endtask

    task automatic test_reset();
        #20;
        for (int i = 0; i < NUM_CH; i++) readCheck(chAddr(i, 8), 32'h0, "reset_ctrl");
        readCheck(STAT, 32'h0, "reset_status");
        checkReady(4'h0, "reset_ready");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_periodic();
        busCycle(1'b1, chAddr(0, 4), 32'd3);
        busCycle(1'b1, chAddr(0, 8), 32'd1);
        waitTicks(1); readCheck(chAddr(0, 0), 32'd1, "periodic_count_t1");
        waitTicks(1); readCheck(chAddr(0, 0), 32'd2, "periodic_count_t2");
        waitTicks(1); readCheck(chAddr(0, 0), 32'd0, "periodic_count_t3");
        readCheck(chAddr(0, 8), 32'h5, "periodic_ctrl_ready");
        checkReady(4'h1, "periodic_ready_out");
        readCheck(STAT, 32'h1, "periodic_status");
        waitTicks(3);
        readCheck(chAddr(0, 8), 32'hD, "overrun_ctrl");
        busCycle(1'b1, chAddr(0, 8), 32'h1);
        readCheck(chAddr(0, 8), 32'h1, "clear_ctrl");
        vectors++;
        if (ready[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_ready0 got %b expected 0", ready[0]);
        end
    endtask

    task automatic test_oneshot();
        busCycle(1'b1, chAddr(2, 4), 32'd2);
        busCycle(1'b1, chAddr(2, 8), 32'd3);
        waitTicks(2);
        readCheck(chAddr(2, 8), 32'h6, "oneshot_ctrl");
        readCheck(chAddr(2, 0), 32'h0, "oneshot_count");
        waitTicks(10);
        readCheck(chAddr(2, 0), 32'h0, "oneshot_count_held");
        readCheck(chAddr(2, 8), 32'h6, "oneshot_ctrl_held");
    endtask

    task automatic test_wrap_limit0();
        busCycle(1'b1, chAddr(1, 4), 32'd0);
        busCycle(1'b1, chAddr(1, 0), 32'hFFFF_FFFF);
        busCycle(1'b1, chAddr(1, 8), 32'd1);
        waitTicks(1);
        readCheck(chAddr(1, 0), 32'h0, "wrap_count");
        readCheck(chAddr(1, 8), 32'h1, "wrap_no_ready");
        for (int k = 0; k < TD && mPresc != TD - 1; k++) busCycle(1'b0, '0, '0);
        busCycle(1'b1, chAddr(1, 0), 32'd7);
        readCheck(chAddr(1, 0), 32'd7, "write_beats_tick");
    endtask

    task automatic test_bus_isolation();
        re = 1'b0; memAddr = chAddr(0, 4);
        #1;
        vectors++;
        if (dataBusOut !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL read_no_re got %h expected 0", dataBusOut);
        end
        busCycle(1'b1, chAddr(0, 12), 32'hFFFF_FFFF);
        busCycle(1'b1, STAT, 32'hFFFF_FFFF);
        readCheck(chAddr(0, 12), 32'h0, "unmapped_read");
        checkAll();
    endtask

    task automatic test_reset_midrun();
        busCycle(1'b1, chAddr(3, 0), 32'd5);
        readCheck(chAddr(3, 0), 32'd5, "pre_reset_count3");
        #2;
        reset = 1'b1;
        #1;
        readCheck(chAddr(3, 0), 32'h0, "async_reset_count3");
        readCheck(chAddr(0, 8), 32'h0, "async_reset_ctrl0");
        readCheck(STAT, 32'h0, "async_reset_status");
        checkReady(4'h0, "async_reset_ready");
        @(posedge clk);
        #1;
        readCheck(chAddr(0, 4), 32'h0, "held_reset_limit0");
        @(negedge clk);
        reset = 1'b0;
        checkAll();
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        int ch, kind;
        for (int n = 0; n < 400; n++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            kind = $urandom_range(0, 2);
            case (kind)
                0: d = 32'($urandom_range(0, 6));
                1: d = 32'($urandom_range(0, 5));
                default: d = 32'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 2) == 0) busCycle(1'b1, chAddr(ch, 4 * kind), d);
            else busCycle(1'b0, '0, '0);
            case ($urandom_range(0, 3))
                0: a = STAT;
                1: a = chAddr($urandom_range(0, NUM_CH - 1), 4 * $urandom_range(0, 3));
                2: a = chAddr($urandom_range(0, NUM_CH - 1), 8);
                default: a = chAddr($urandom_range(0, NUM_CH - 1), 0);
            endcase
            readCheck(a, modelRead(a), "random_read");
            if (n % 50 == 49) checkAll();
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_wrap_limit0();
        test_bus_isolation();
        test_reset_midrun();
        test_random();
        checkAll();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
